// File: rtl/ps2_note_decoder_pkg.sv
// Shared constants, types and helpers for the PS/2 note decoder.
// It holds the scan codes, the half-period table, the FSM states and the fallback encoder.
package ps2_note_decoder_pkg;

    localparam int NUM_NOTES = 7;
    localparam logic [2:0] NOTE_NONE = 3'd7;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Controller responses that never represent a key event
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_ERROR   = 8'hFF;
    localparam logic [7:0] SC_OVERRUN = 8'h00;

    localparam logic [18:0] HP_A = 19'd113636;
    localparam logic [18:0] HP_B = 19'd101214;
    localparam logic [18:0] HP_C = 19'd95555;
    localparam logic [18:0] HP_D = 19'd85132;
    localparam logic [18:0] HP_E = 19'd75842;
    localparam logic [18:0] HP_F = 19'd71586;
    localparam logic [18:0] HP_G = 19'd63776;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    function automatic logic [18:0] note_half_period(input logic [2:0] idx);
        logic [18:0] hp;
        case (idx)
            3'd0:    hp = HP_A;
            3'd1:    hp = HP_B;
            3'd2:    hp = HP_C;
            3'd3:    hp = HP_D;
            3'd4:    hp = HP_E;
            3'd5:    hp = HP_F;
            3'd6:    hp = HP_G;
            default: hp = 19'd0;
        endcase
        return hp;
    endfunction

    function automatic logic is_ignored_code(input logic [7:0] code);
        return (code == SC_ACK) || (code == SC_BAT_OK) || (code == SC_ECHO) ||
               (code == SC_RESEND) || (code == SC_ERROR) || (code == SC_OVERRUN);
    endfunction

    // Lowest set bit wins; an empty mask yields NOTE_NONE
    function automatic logic [2:0] lowest_set_idx(input logic [NUM_NOTES-1:0] mask);
        logic [2:0] r;
        r = NOTE_NONE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_note_decoder_note_lut.sv
// Combinational scan-code decoder for the seven note keys.
// It is shared by the make path and the break path.
module ps2_note_decoder_note_lut
    import ps2_note_decoder_pkg::*;
(
    input  logic [7:0]  scan_code,
    output logic        is_note,
    output logic [2:0]  idx,
    output logic [18:0] half_period
);

    always_comb begin
        is_note     = 1'b1;
        idx         = NOTE_NONE;
        half_period = 19'd0;
        case (scan_code)
            SC_A: begin idx = 3'd0; half_period = HP_A; end
            SC_B: begin idx = 3'd1; half_period = HP_B; end
            SC_C: begin idx = 3'd2; half_period = HP_C; end
            SC_D: begin idx = 3'd3; half_period = HP_D; end
            SC_E: begin idx = 3'd4; half_period = HP_E; end
            SC_F: begin idx = 3'd5; half_period = HP_F; end
            SC_G: begin idx = 3'd6; half_period = HP_G; end
            default: is_note = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// Turns PS/2 make/break/extended byte sequences into a held-key mask and one selected note.
// The most recently pressed key wins; releasing it falls back to the lowest held key.
module ps2_note_decoder
    import ps2_note_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_en,
    output logic        note_on,
    output logic [2:0]  note_idx,
    output logic [18:0] half_period,
    output logic [6:0]  held_mask,
    output logic        note_change,
    output logic [7:0]  last_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;

    logic [6:0]  held_mask_reg,   held_mask_next;
    logic [2:0]  note_idx_reg,    note_idx_next;
    logic [18:0] half_period_reg, half_period_next;
    logic [7:0]  last_code_reg,   last_code_next;
    logic        note_on_reg;
    logic        note_change_reg;

    logic        lut_is_note;
    logic [2:0]  lut_idx;
    logic [18:0] lut_half_period;
    logic [6:0]  released_mask;

    ps2_note_decoder_note_lut note_lut (
        .scan_code   (ps2_data),
        .is_note     (lut_is_note),
        .idx         (lut_idx),
        .half_period (lut_half_period)
    );

    assign released_mask = held_mask_reg & ~(7'd1 << lut_idx);

    // Note bookkeeping for the byte arriving this cycle, interpreted in the current state
    always_comb begin
        held_mask_next   = held_mask_reg;
        note_idx_next    = note_idx_reg;
        half_period_next = half_period_reg;
        last_code_next   = last_code_reg;
        if (ps2_data_en) begin
            case (state_reg)
                IDLE: begin
                    if ((ps2_data != SC_BREAK) && (ps2_data != SC_EXT) &&
                        !is_ignored_code(ps2_data)) begin
                        last_code_next = ps2_data;
                        // Typematic repeats of an already-held key change nothing
                        if (lut_is_note && !held_mask_reg[lut_idx]) begin
                            held_mask_next   = held_mask_reg | (7'd1 << lut_idx);
                            note_idx_next    = lut_idx;
                            half_period_next = lut_half_period;
                        end
                    end
                end
                BRK: begin
                    last_code_next = ps2_data;
                    if (lut_is_note) begin
                        held_mask_next = released_mask;
                        if (note_idx_reg == lut_idx) begin
                            note_idx_next    = lowest_set_idx(released_mask);
                            half_period_next = note_half_period(lowest_set_idx(released_mask));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            timeout_cnt_reg <= '0;
            held_mask_reg   <= '0;
            note_idx_reg    <= NOTE_NONE;
            note_on_reg     <= 1'b0;
            half_period_reg <= '0;
            note_change_reg <= 1'b0;
            last_code_reg   <= 8'h00;
        end else begin
            held_mask_reg   <= held_mask_next;
            note_idx_reg    <= note_idx_next;
            note_on_reg     <= (note_idx_next != NOTE_NONE);
            half_period_reg <= half_period_next;
            last_code_reg   <= last_code_next;
            // note_on is a function of note_idx, so comparing indices covers both
            note_change_reg <= (note_idx_next != note_idx_reg);

            if (ps2_data_en) begin
                timeout_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (ps2_data == SC_BREAK) begin
                            state_reg <= BRK;
                        end else if (ps2_data == SC_EXT) begin
                            state_reg <= EXT;
                        end
                    end
                    EXT:     state_reg <= (ps2_data == SC_BREAK) ? EXT_BRK : IDLE;
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE) begin
                if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    state_reg       <= IDLE;
                    timeout_cnt_reg <= '0;
                end else begin
                    timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                end
            end else begin
                timeout_cnt_reg <= '0;
            end
        end
    end

    assign note_on     = note_on_reg;
    assign note_idx    = note_idx_reg;
    assign half_period = half_period_reg;
    assign held_mask   = held_mask_reg;
    assign note_change = note_change_reg;
    assign last_code   = last_code_reg;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: directed scenarios plus random byte streams,
// with every cycle compared against a key-level reference model.
module tb_ps2_note_decoder;

    localparam int T = 16;

    logic        CLOCK_50    = 1'b0;
    logic        resetn      = 1'b0;
    logic [7:0]  ps2_data    = 8'h00;
    logic        ps2_data_en = 1'b0;
    logic        note_on;
    logic [2:0]  note_idx;
    logic [18:0] half_period;
    logic [6:0]  held_mask;
    logic        note_change;
    logic [7:0]  last_code;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_note_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .note_on     (note_on),
        .note_idx    (note_idx),
        .half_period (half_period),
        .held_mask   (held_mask),
        .note_change (note_change),
        .last_code   (last_code)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int cyc      = 0;

    logic [7:0] code_tab [7] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34};
    int         hp_tab   [7] = '{113636, 101214, 95555, 85132, 75842, 71586, 63776};
    logic [7:0] ign_tab  [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFF, 8'h00};

    // Reference model: which keys are down, which one sounds, and any unfinished prefix bytes
    bit         held [7];
    int         cur         = 7;
    logic [7:0] m_last      = 8'h00;
    bit         m_change    = 1'b0;
    logic [7:0] pending [$];
    int         last_strobe = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 7; i++) begin
            if (code_tab[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic bit ignored(input logic [7:0] b);
        for (int i = 0; i < 6; i++) begin
            if (ign_tab[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) held[i] = 1'b0;
        cur      = 7;
        m_last   = 8'h00;
        m_change = 1'b0;
        pending.delete();
    endtask

    task automatic model_strobe(input logic [7:0] d);
        int prev;
        int k;
        prev = cur;
        // A prefix left waiting longer than T cycles has been abandoned
        if (pending.size() != 0 && (cyc - last_strobe) > T) pending.delete();
        last_strobe = cyc;
        k = note_of(d);
        if (pending.size() == 0) begin
            if (d == 8'hF0 || d == 8'hE0) begin
                pending.push_back(d);
            end else if (!ignored(d)) begin
                m_last = d;
                if (k >= 0 && !held[k]) begin
                    held[k] = 1'b1;
                    cur = k;
                end
            end
        end else if (pending[0] == 8'hF0) begin
            pending.delete();
            m_last = d;
            if (k >= 0) begin
                held[k] = 1'b0;
                if (cur == k) begin
                    cur = 7;
                    for (int i = 6; i >= 0; i--) if (held[i]) cur = i;
                end
            end
        end else begin
            if (pending.size() == 1 && d == 8'hF0) pending.push_back(d);
            else pending.delete();
        end
        m_change = (prev != cur);
    endtask

    task automatic check_outputs();
        logic [6:0] mask;
        for (int i = 0; i < 7; i++) mask[i] = held[i];
        check_eq("note_on", 32'(note_on), 32'(cur != 7));
        check_eq("note_idx", 32'(note_idx), 32'(cur));
        check_eq("half_period", 32'(half_period), (cur == 7) ? 32'd0 : 32'(hp_tab[cur]));
        check_eq("held_mask", 32'(held_mask), 32'(mask));
        check_eq("note_change", 32'(note_change), 32'(m_change));
        check_eq("last_code", 32'(last_code), 32'(m_last));
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        @(negedge CLOCK_50);
        ps2_data_en = en;
        ps2_data    = en ? d : 8'($urandom_range(0, 255));
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (en) model_strobe(d);
        else    m_change = 1'b0;
        check_outputs();
        if (note_change) pulses++;
        if (en) $display("cyc=%0d byte=%h note_idx=%0d note_on=%0b held=%b hp=%0d",
                         cyc, d, note_idx, note_on, held_mask, half_period);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic reset_pulse();
        @(negedge CLOCK_50);
        resetn      = 1'b0;
        ps2_data_en = 1'b0;
        @(posedge CLOCK_50);
        #1;
        cyc++;
        model_reset();
        check_outputs();
        resetn = 1'b1;
        pulses = 0;
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        // Reset values
        reset_pulse();
        check_eq("rst_idx", 32'(note_idx), 32'd7);
        check_eq("rst_hp", 32'(half_period), 32'd0);

        // Single make of A
        tick(1'b1, 8'h1C);
        check_eq("tp1_idx", 32'(note_idx), 32'd0);
        check_eq("tp1_hp", 32'(half_period), 32'd113636);
        check_eq("tp1_mask", 32'(held_mask), 32'b0000001);
        idle(3);
        check_eq("tp1_pulses", 32'(pulses), 32'd1);

        // A, then G, then release G -> fallback to A
        reset_pulse();
        tick(1'b1, 8'h1C); idle(2);
        tick(1'b1, 8'h34);
        check_eq("tp2_hp_g", 32'(half_period), 32'd63776);
        idle(2);
        tick(1'b1, 8'hF0); tick(1'b1, 8'h34);
        check_eq("tp2_hp_a", 32'(half_period), 32'd113636);
        idle(2);
        check_eq("tp2_pulses", 32'(pulses), 32'd3);

        // Typematic repeats, back to back
        reset_pulse();
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h1C);
        idle(2);
        check_eq("tp3_pulses", 32'(pulses), 32'd1);
        check_eq("tp3_mask", 32'(held_mask), 32'b0000001);

        // Extended sequences never touch notes; FSM back in IDLE afterwards
        reset_pulse();
        tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'h1C);
        tick(1'b1, 8'hE0); tick(1'b1, 8'h1C);
        check_eq("tp4_mask", 32'(held_mask), 32'd0);
        tick(1'b1, 8'h1C);
        check_eq("tp4_on", 32'(note_on), 32'd1);

        // Abandoned break prefix
        reset_pulse();
        tick(1'b1, 8'hF0); idle(T + 4);
        tick(1'b1, 8'h1C);
        check_eq("tp5_on", 32'(note_on), 32'd1);

        // Timeout boundary: strobe on the timeout cycle still completes the break
        tick(1'b1, 8'hF0); idle(T - 1); tick(1'b1, 8'h1C);
        check_eq("tp5_edge_rel", 32'(note_on), 32'd0);
        tick(1'b1, 8'h1C);
        tick(1'b1, 8'hF0); idle(T); tick(1'b1, 8'h1C);
        check_eq("tp5_edge_late", 32'(note_on), 32'd1);

        // Reset in the middle of a break sequence
        reset_pulse();
        tick(1'b1, 8'h21); tick(1'b1, 8'hF0);
        reset_pulse();
        check_eq("tp6_rst_mask", 32'(held_mask), 32'd0);
        tick(1'b1, 8'h21);
        check_eq("tp6_idx", 32'(note_idx), 32'd2);
        check_eq("tp6_hp", 32'(half_period), 32'd95555);

        // Random byte streams with varied gaps and occasional resets
        reset_pulse();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      b = code_tab[$urandom_range(0, 6)];
            else if (r < 62) b = 8'hF0;
            else if (r < 70) b = 8'hE0;
            else if (r < 78) b = ign_tab[$urandom_range(0, 5)];
            else             b = 8'($urandom_range(0, 255));
            tick(1'b1, b);
            r = $urandom_range(0, 99);
            if (r < 50)      begin end
            else if (r < 85) idle($urandom_range(1, 3));
            else if (r < 98) idle($urandom_range(T - 2, T + 2));
            else             reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Converts the raw byte stream from the PS/2 controller into a stable note selection for the square-wave tone generator. It sits between the PS/2 receiver and the tone/volume stage. It parses make, break (F0) and extended (E0) sequences and tracks which of the seven note keys (A–G) are held. It applies last-pressed priority with a deterministic fallback on release, and outputs the selected note's half-period count in CLOCK_50 cycles.

## Interface
- TIMEOUT_CYCLES, default 1000000: cycles a prefix state may wait for its follow-up byte before abandoning the sequence (20 ms at 50 MHz).
- CLOCK_50  in  1  system clock, 50 MHz; all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- ps2_data  in  8  received byte from the PS/2 receiver.
- ps2_data_en  in  1  one-cycle strobe; ps2_data is valid when this is high.
- note_on  out  1  a note key is currently selected.
- note_idx  out  3  selected note: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=none.
- half_period  out  19  tone half-period in CLOCK_50 cycles; 0 when note_on=0.
- held_mask  out  7  bit i set while note i is held.
- note_change  out  1  one-cycle pulse when note_on or note_idx changes.
- last_code  out  8  last accepted make/break scan code, for HEX display.

## Operation
- Note table (scan code -> half_period):
  - A 1C -> 113636
  - B 32 -> 101214
  - C 21 -> 95555
  - D 23 -> 85132
  - E 24 -> 75842
  - F 2B -> 71586
  - G 34 -> 63776
- All other codes are non-note.
- FSM states: IDLE, BRK, EXT, EXT_BRK. State changes only on a strobe, except on timeout.
- IDLE, byte F0 -> BRK. Byte E0 -> EXT. Bytes FA, AA, EE, FE, FF, 00 are ignored and the FSM stays in IDLE. Any other byte is a make code and the FSM stays in IDLE.
- Make of a note key:
  - If the key's bit was clear: set the bit, make the key current, and update last_code.
  - If the bit was already set (typematic repeat): no change and no pulse. last_code still updates.
- Make of a non-note key: last_code updates; note state is unchanged.
- BRK, any byte -> IDLE. The byte is a release: clear its bit if it is a note key, and update last_code.
  - If the released key was current: select the lowest-index bit still set in held_mask. If none are set, set note_on=0 and note_idx=7.
  - If the released key was not current, or was not held: selection is unchanged.
- EXT, byte F0 -> EXT_BRK; any other byte -> IDLE and is ignored.
- EXT_BRK, any byte -> IDLE and is ignored. Extended keys never affect notes.
- Timeout: in any non-IDLE state the counter increments each cycle without a strobe. When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE with no other effect. The counter clears on every strobe and in IDLE.
- A strobe and a timeout in the same cycle: the strobe wins, the byte is processed in the current state, and the counter clears.
- half_period and note_on are derived from note_idx and are registered together with it, so they are always mutually consistent.
- Reset, including mid-sequence:
  - state=IDLE, counter=0, held_mask=0.
  - note_on=0, note_idx=7, half_period=0, note_change=0, last_code=00.

## Timing
- Latency: a strobe in cycle N updates held_mask, note_idx, note_on, half_period and last_code at the edge ending cycle N; they are visible in cycle N+1.
- note_change is high for exactly cycle N+1 iff note_on or note_idx differs from its cycle-N value.
- Back-to-back strobes on consecutive cycles must each be processed; no strobe may be dropped.
- ps2_data is sampled only when ps2_data_en=1.

## Structure
- Shared package holds:
  - scan-code constants for A–G, F0, E0 and the ignored bytes;
  - the half-period table;
  - NOTE_NONE=3'd7;
  - the FSM state enum.
- Sub-module note_lut: combinational, scan code -> {is_note, idx[2:0], half_period[18:0]}. It is used for both make and break decoding.
- The priority fallback is a lowest-set-bit encoder on the 7-bit mask.

## Test plan
- Reset, then a 1C strobe -> next cycle note_on=1, note_idx=0, half_period=113636, held_mask=0000001, one note_change pulse.
- 1C, then 34 (G), then F0 34 -> G becomes current (63776), then falls back to A (113636); note_change pulses three times.
- Ten repeated 1C strobes -> a single note_change pulse, held_mask constant.
- E0 F0 1C, then E0 1C -> no change to held_mask or note; FSM ends in IDLE.
- F0 followed by silence for TIMEOUT_CYCLES (overridden to 16) -> FSM returns to IDLE. A subsequent 1C is treated as a make (note_on=1), not as a release.
- Hold C, send F0, assert resetn=0 for one cycle, then send 21 -> after reset all outputs are at reset values, and 21 acts as a make (note_idx=2, half_period=95555).
